// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable/flush sequencing: memory-wait freeze, data-done masking, halt drain.
// Optional PIPE_STATS_EN adds saturating stall/flush counters. Outputs are combinational (0 latency).
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic CLK,
    input  logic RST,
    input  logic ihit,
    input  logic dhit,
    input  logic mem_dREN,
    input  logic mem_dWEN,
    input  logic mem_halt,
    input  logic hazard,
    input  logic branch,
    input  logic jump,
    output logic pc_en,
    output logic pc_redirect,
    output logic ifid_en,
    output logic ifid_flush,
    output logic idex_en,
    output logic idex_flush,
    output logic exmem_en,
    output logic memwb_en,
    output logic mem_dmask,
    output logic halt_out
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, DDONE, HALT} state_t;

    state_t state;
    logic   memreq;
    logic   advance;
    logic   redirect;

    always_comb begin
        memreq   = (mem_dREN | mem_dWEN) & (state != DDONE);
        // Gate with RST so every output reads 0 while reset is held.
        advance  = ihit & (~memreq | dhit) & (state != HALT) & ~RST;
        redirect = advance & ~hazard & (branch | jump);
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        mem_dmask   = (state == DDONE);
        halt_out    = (state == HALT);
        if (advance) begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_en  = 1'b1;
            if (hazard) begin
                // Hold the ID instruction and insert a bubble into EX.
                idex_flush = 1'b1;
            end else begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                pc_redirect = redirect;
                ifid_flush  = redirect;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (advance && mem_halt)
                        state <= HALT;
                    else if (memreq && dhit && !ihit)
                        state <= DDONE;
                end
                DDONE: begin
                    if (advance && mem_halt)
                        state <= HALT;
                    else if (ihit)
                        state <= RUN;
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALT) begin
            if ((!advance || hazard) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
